// File: rtl/ex_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared opcode constants, divider FSM state codes and small helpers for the
// EX-stage multiply-accumulate / divide engine (ex_muldiv + div_unit).
// ---------------------------------------------------------------------------
package ex_muldiv_pkg;

    // EX-stage opcodes handled by this block
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    // Divider FSM state codes
    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    localparam logic RSTENABLE = 1'b1;

    // HI:LO pair
    typedef logic [63:0] dreg_t;

    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MADD = 2'd1,
        MD_DIV  = 2'd2
    } md_class_e;

    function automatic md_class_e md_classify(input logic [7:0] op);
        md_class_e c;
        case (op)
            EXE_MADD_OP, EXE_MADDU_OP,
            EXE_MSUB_OP, EXE_MSUBU_OP: c = MD_MADD;
            EXE_DIV_OP, EXE_DIVU_OP:   c = MD_DIV;
            default:                   c = MD_NONE;
        endcase
        return c;
    endfunction

    function automatic logic md_is_signed(input logic [7:0] op);
        return (op == EXE_MADD_OP) || (op == EXE_MSUB_OP) || (op == EXE_DIV_OP);
    endfunction

    function automatic logic md_is_sub(input logic [7:0] op);
        return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
    endfunction

endpackage

// File: rtl/ex_muldiv_div.sv
// ---------------------------------------------------------------------------
// div_unit
// Multi-cycle restoring divider: one quotient bit per clock, DIV_W steps.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_i        a divide op is present in EX (held until EX advances)
//   annul_i        flush: abandon any division in progress
//   signed_i       operands are two's complement
//   dividend_i     dividend (rs)
//   divisor_i      divisor (rt)
//   result_o       {remainder, quotient}
//   ready_o        result_o valid (END state)
// ---------------------------------------------------------------------------
module div_unit
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [DIV_W-1:0]     dividend_i,
    input  logic [DIV_W-1:0]     divisor_i,
    output logic [2*DIV_W-1:0]   result_o,
    output logic                 ready_o
);

    localparam int ITER_W = $clog2(DIV_W);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIV_W - 1);

    logic [1:0]        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [DIV_W-1:0]  rem_q, rem_d;
    // quo_q starts as the dividend and is shifted out MSB-first while the
    // quotient bits shift in from the bottom.
    logic [DIV_W-1:0]  quo_q, quo_d;
    logic [DIV_W-1:0]  divisor_q, divisor_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic [DIV_W:0]    rem_sh;
    logic [DIV_W:0]    trial;
    logic [DIV_W-1:0]  step_rem;
    logic [DIV_W-1:0]  step_quo;
    logic              dvd_neg;
    logic              dvs_neg;

    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] x,
                                                  input logic             neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    // One restoring step. rem < divisor always holds, so the shifted
    // remainder fits in DIV_W+1 bits and the sign of the trial subtraction
    // is its top bit.
    always_comb begin
        rem_sh = {rem_q, quo_q[DIV_W-1]};
        trial  = rem_sh - {1'b0, divisor_q};
        if (trial[DIV_W]) begin
            step_rem = rem_sh[DIV_W-1:0];
            step_quo = {quo_q[DIV_W-2:0], 1'b0};
        end else begin
            step_rem = trial[DIV_W-1:0];
            step_quo = {quo_q[DIV_W-2:0], 1'b1};
        end
    end

    assign dvd_neg = signed_i & dividend_i[DIV_W-1];
    assign dvs_neg = signed_i & divisor_i[DIV_W-1];

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    if (divisor_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        iter_d    = '0;
                        rem_d     = '0;
                        quo_d     = cond_neg(dividend_i, dvd_neg);
                        divisor_d = cond_neg(divisor_i, dvs_neg);
                        neg_quo_d = dvd_neg ^ dvs_neg;
                        neg_rem_d = dvd_neg;
                    end
                end
            end
            DIV_BYZERO: begin
                rem_d   = '0;
                quo_d   = '0;
                state_d = DIV_END;
            end
            DIV_ON: begin
                rem_d  = step_rem;
                quo_d  = step_quo;
                iter_d = iter_q + 1'b1;
                if (iter_q == LAST_ITER) begin
                    // Sign fix-up folded into the final step so END
                    // presents the finished result.
                    rem_d   = cond_neg(step_rem, neg_rem_q);
                    quo_d   = cond_neg(step_quo, neg_quo_q);
                    iter_d  = '0;
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                // Hold the result until EX moves on to a non-divide op.
                if (!start_i) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase

        if (annul_i) begin
            state_d = DIV_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RSTENABLE) begin
            state_q   <= DIV_FREE;
            iter_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign ready_o  = (state_q == DIV_END);
    assign result_o = {rem_q, quo_q};

endmodule

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
// EX-stage multi-cycle arithmetic: MADD/MADDU/MSUB/MSUBU (two-pass through
// ex_mem using hilo_temp/cnt) and DIV/DIVU (via div_unit).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   aluop_i           EX opcode
//   reg1_i, reg2_i    rs / rt operands
//   hi_i, lo_i        current (forwarded) HI/LO
//   hilo_i, cnt_i     partial product and pass count returned by ex_mem
//   annul_i           flush, aborts a division
//   hilo_temp_o       partial product to ex_mem
//   cnt_o             next pass count to ex_mem
//   stallreq_o        pipeline stall request
//   whilo_o           HI/LO write enable
//   hi_o, lo_o        HI/LO write data
// DIV_W is the divider width and matches the 32-bit operand width.
// ---------------------------------------------------------------------------
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    input  logic        annul_i,
    output logic [63:0] hilo_temp_o,
    output logic [1:0]  cnt_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    md_class_e op_class;
    logic      op_signed;
    logic      op_sub;
    dreg_t     prod;
    dreg_t     acc_sum;
    dreg_t     madd_res_q, madd_res_d;
    logic [63:0] div_res;
    logic        div_ready;

    assign op_class  = md_classify(aluop_i);
    assign op_signed = md_is_signed(aluop_i);
    assign op_sub    = md_is_sub(aluop_i);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product
    // are then correct for both signed and unsigned operands.
    always_comb begin
        logic [63:0] a_ext;
        logic [63:0] b_ext;
        a_ext = {{32{op_signed & reg1_i[31]}}, reg1_i};
        b_ext = {{32{op_signed & reg2_i[31]}}, reg2_i};
        prod  = a_ext * b_ext;
        if (op_sub) begin
            prod = ~prod + 64'd1;
        end
    end

    assign acc_sum = hilo_i + {hi_i, lo_i};

    div_unit #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (op_class == MD_DIV),
        .annul_i    (annul_i),
        .signed_i   (op_signed),
        .dividend_i (reg1_i),
        .divisor_i  (reg2_i),
        .result_o   (div_res),
        .ready_o    (div_ready)
    );

    // The accumulated result is captured on the summing pass so that a
    // later-stage stall (cnt_i==2) replays it even if HI/LO forwarding moves.
    always_comb begin
        madd_res_d = madd_res_q;
        if (op_class == MD_MADD && cnt_i == 2'd1) begin
            madd_res_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RSTENABLE) begin
            madd_res_q <= '0;
        end else begin
            madd_res_q <= madd_res_d;
        end
    end

    always_comb begin
        hilo_temp_o = '0;
        cnt_o       = 2'd0;
        stallreq_o  = 1'b0;
        whilo_o     = 1'b0;
        hi_o        = '0;
        lo_o        = '0;

        if (rst != RSTENABLE) begin
            case (op_class)
                MD_MADD: begin
                    case (cnt_i)
                        2'd0: begin
                            hilo_temp_o = prod;
                            cnt_o       = 2'd1;
                            stallreq_o  = 1'b1;
                        end
                        2'd1: begin
                            hilo_temp_o   = hilo_i;
                            cnt_o         = 2'd2;
                            whilo_o       = 1'b1;
                            {hi_o, lo_o}  = acc_sum;
                        end
                        default: begin
                            hilo_temp_o   = hilo_i;
                            cnt_o         = 2'd2;
                            whilo_o       = 1'b1;
                            {hi_o, lo_o}  = madd_res_q;
                        end
                    endcase
                end
                MD_DIV: begin
                    stallreq_o = ~div_ready;
                    if (div_ready && !annul_i) begin
                        whilo_o = 1'b1;
                        hi_o    = div_res[63:32];
                        lo_o    = div_res[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2, hi_i, lo_i;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic        annul;
    logic [63:0] hilo_temp_o;
    logic [1:0]  cnt_o;
    logic        stallreq_o, whilo_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.DIV_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop),
        .reg1_i      (reg1),
        .reg2_i      (reg2),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .hilo_i      (hilo_i),
        .cnt_i       (cnt_i),
        .annul_i     (annul),
        .hilo_temp_o (hilo_temp_o),
        .cnt_o       (cnt_o),
        .stallreq_o  (stallreq_o),
        .whilo_o     (whilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_madd(input logic [7:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] h,
                                       input logic [31:0] l, output logic [63:0] p,
                                       output logic [63:0] s);
        longint sp;
        if (op == EXE_MADD_OP || op == EXE_MSUB_OP) begin
            sp = longint'(int'(a)) * longint'(int'(b));
            p  = 64'(sp);
        end else begin
            p = {32'b0, a} * {32'b0, b};
        end
        if (op == EXE_MSUB_OP || op == EXE_MSUBU_OP) p = -p;
        s = p + {h, l};
    endfunction

    function automatic void model_div(input logic [7:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] h,
                                      output logic [31:0] l, output int lat);
        int sa, sb;
        if (b == 32'd0) begin
            h = 0; l = 0; lat = 2;
        end else begin
            lat = 33;
            if (op == EXE_DIV_OP) begin
                sa = int'(a); sb = int'(b);
                l = 32'(sa / sb);
                h = 32'(sa % sb);
            end else begin
                l = a / b;
                h = a % b;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; annul = 1'b0;
        aluop = EXE_MADD_OP; reg1 = 3; reg2 = 4; cnt_i = 0;
        hilo_i = 64'h1234; hi_i = 1; lo_i = 2;
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({hilo_temp_o, cnt_o, stallreq_o, whilo_o, hi_o, lo_o} !== '0)
            $display("FAIL reset_outputs: got temp=%h cnt=%0d stall=%b whilo=%b hi=%h lo=%h, expected all 0",
                     hilo_temp_o, cnt_o, stallreq_o, whilo_o, hi_o, lo_o);
        tick();
        rst = 1'b0; aluop = EXE_NOP_OP; cnt_i = 0; hilo_i = 0;
        tick();
    endtask

    task automatic test_madd(input logic [7:0] op, input logic [31:0] h, input logic [31:0] l,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp_p, input logic [63:0] exp_s);
        aluop = op; hi_i = h; lo_i = l; reg1 = a; reg2 = b; cnt_i = 0; hilo_i = 0;
        @(negedge clk);
        n_cmp++;
        if ({hilo_temp_o, cnt_o, stallreq_o, whilo_o} !== {exp_p, 2'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL madd_pass0 op=%h: got temp=%h cnt=%0d stall=%b whilo=%b, expected temp=%h cnt=1 stall=1 whilo=0",
                     op, hilo_temp_o, cnt_o, stallreq_o, whilo_o, exp_p);
        end
        tick();
        hilo_i = exp_p; cnt_i = 1;
        @(negedge clk);
        n_cmp++;
        if ({hi_o, lo_o, hilo_temp_o, cnt_o, stallreq_o, whilo_o} !== {exp_s, exp_p, 2'd2, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL madd_pass1 op=%h: got hilo=%h temp=%h cnt=%0d stall=%b whilo=%b, expected hilo=%h temp=%h cnt=2 stall=0 whilo=1",
                     op, {hi_o, lo_o}, hilo_temp_o, cnt_o, stallreq_o, whilo_o, exp_s, exp_p);
        end
        tick();
        // later-stage stall: HI/LO forwarding may change, result must hold
        cnt_i = 2; hi_i = $urandom; lo_i = $urandom;
        @(negedge clk);
        n_cmp++;
        if ({hi_o, lo_o, cnt_o, stallreq_o, whilo_o} !== {exp_s, 2'd2, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL madd_hold op=%h: got hilo=%h cnt=%0d stall=%b whilo=%b, expected hilo=%h cnt=2 stall=0 whilo=1",
                     op, {hi_o, lo_o}, cnt_o, stallreq_o, whilo_o, exp_s);
        end
        tick();
        aluop = EXE_NOP_OP; cnt_i = 0; hilo_i = 0;
        tick();
    endtask

    task automatic test_madd_random(input int n);
        logic [7:0]  ops [4];
        logic [7:0]  op;
        logic [31:0] a, b, h, l;
        logic [63:0] p, s;
        ops[0] = EXE_MADD_OP; ops[1] = EXE_MADDU_OP; ops[2] = EXE_MSUB_OP; ops[3] = EXE_MSUBU_OP;
        for (int i = 0; i < n; i++) begin
            op = ops[i % 4];
            a = $urandom; b = $urandom; h = $urandom; l = $urandom;
            if (i == 4) begin a = 32'h8000_0000; b = 32'h8000_0000; end
            model_madd(op, a, b, h, l, p, s);
            test_madd(op, h, l, a, b, p, s);
        end
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int found;
        logic early_whilo;
        logic got_whilo;
        logic [31:0] got_hi, got_lo;
        found = -1; early_whilo = 1'b0; got_whilo = 1'b0; got_hi = 0; got_lo = 0;
        aluop = op; reg1 = a; reg2 = b; cnt_i = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stallreq_o) begin
                found = c; got_whilo = whilo_o; got_hi = hi_o; got_lo = lo_o;
                break;
            end
            if (whilo_o) early_whilo = 1'b1;
            tick();
            if (c == 0) begin reg1 = $urandom; reg2 = $urandom; end
        end
        n_cmp++;
        if (found != exp_lat || early_whilo) begin
            n_bad++;
            $display("FAIL div_latency op=%h a=%h b=%h: got ready cycle %0d (early whilo=%b), expected cycle %0d",
                     op, a, b, found, early_whilo, exp_lat);
        end
        n_cmp++;
        if ({got_whilo, got_hi, got_lo} !== {1'b1, exp_hi, exp_lo}) begin
            n_bad++;
            $display("FAIL div_result op=%h a=%h b=%h: got whilo=%b hi=%h lo=%h, expected whilo=1 hi=%h lo=%h",
                     op, a, b, got_whilo, got_hi, got_lo, exp_hi, exp_lo);
        end
        tick();
        aluop = EXE_NOP_OP;
        @(negedge clk);
        n_cmp++;
        if ({stallreq_o, whilo_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL div_release: got stall=%b whilo=%b, expected 0 0", stallreq_o, whilo_o);
        end
        tick();
    endtask

    task automatic test_div_random(input int n);
        logic [7:0]  op;
        logic [31:0] a, b, h, l;
        int lat;
        for (int i = 0; i < n; i++) begin
            op = (i % 2 == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            if (i == 5) b = 0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 1;
            model_div(op, a, b, h, l, lat);
            run_div(op, a, b, lat, h, l);
        end
    endtask

    task automatic test_abort(input bit use_rst);
        logic [31:0] h, l;
        int lat;
        aluop = EXE_DIV_OP; reg1 = -100; reg2 = 7; cnt_i = 0;
        for (int c = 0; c < 10; c++) tick();
        if (use_rst) rst = 1'b1; else annul = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (whilo_o !== 1'b0 || (use_rst && stallreq_o !== 1'b0)) begin
            n_bad++;
            $display("FAIL abort_cycle rst=%0d: got whilo=%b stall=%b, expected whilo=0", use_rst, whilo_o, stallreq_o);
        end
        tick();
        rst = 1'b0; annul = 1'b0;
        // FSM must be FREE now, so a fresh division takes the full latency
        model_div(EXE_DIV_OP, 32'd1000, -32'd3, h, l, lat);
        run_div(EXE_DIV_OP, 32'd1000, -32'd3, lat, h, l);
    endtask

    task automatic test_non_muldiv();
        logic [7:0] op;
        for (int i = 0; i < 4; i++) begin
            do op = 8'($urandom); while (op == EXE_MADD_OP || op == EXE_MADDU_OP ||
                                          op == EXE_MSUB_OP || op == EXE_MSUBU_OP ||
                                          op == EXE_DIV_OP  || op == EXE_DIVU_OP);
            aluop = op; cnt_i = 2'($urandom_range(0, 2)); hilo_i = {$urandom, $urandom};
            reg1 = $urandom; reg2 = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({hilo_temp_o, cnt_o, stallreq_o, whilo_o} !== '0) begin
                n_bad++;
                $display("FAIL non_muldiv op=%h: got temp=%h cnt=%0d stall=%b whilo=%b, expected all 0",
                         op, hilo_temp_o, cnt_o, stallreq_o, whilo_o);
            end
            tick();
        end
        aluop = EXE_NOP_OP; cnt_i = 0; hilo_i = 0;
    endtask

    initial begin
        test_reset();
        if (n_cmp > 0 && {hilo_temp_o, cnt_o} === 'x) n_bad++;
        test_madd(EXE_MADD_OP, 32'd0, 32'd5, 32'd3, 32'd4, 64'd12, 64'd17);
        test_madd(EXE_MSUB_OP, 32'd0, 32'd10, 32'd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 64'd4);
        test_madd_random(8);
        test_non_muldiv();
        run_div(EXE_DIV_OP, -32'd7, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, 33, 32'd15, 32'h0FFF_FFFF);
        run_div(EXE_DIV_OP, 32'd1234, 32'd0, 2, 32'd0, 32'd0);
        test_div_random(8);
        test_abort(1'b0);
        test_abort(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
